// File: rtl/counter_pkg.sv
// Shared constants for the modulo counter: boundary-mode encodings and default width.
package counter_pkg;

  localparam int MODE_WRAP     = 0;
  localparam int MODE_SAT      = 1;
  localparam int DEFAULT_WIDTH = 4;

endpackage : counter_pkg

// File: rtl/counter_next.sv
// Combinational next-count logic for mod_counter: one step up or down within 0..lim,
// flagging a boundary event when the step runs off either end of the range.
module counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] lim,
  input  logic             up,
  input  logic             en,
  output logic [WIDTH-1:0] nxt,
  output logic             boundary
);

  localparam bit SAT_MODE = (SATURATE == MODE_SAT);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  always_comb begin
    nxt      = count;
    boundary = 1'b0;
    if (en) begin
      if (up) begin
        // count above lim (after lim was lowered) is treated as already at the top
        if (count < lim) begin
          nxt = count + ONE;
        end else begin
          boundary = 1'b1;
          nxt      = SAT_MODE ? lim : ZERO;
        end
      end else begin
        if (count != ZERO) begin
          nxt = count - ONE;
        end else begin
          boundary = 1'b1;
          nxt      = SAT_MODE ? ZERO : lim;
        end
      end
    end
  end

endmodule : counter_next

// File: rtl/mod_counter.sv
// Up/down counter over a runtime range 0..lim with wrap or saturate behaviour,
// a one-cycle terminal-count pulse and a sticky boundary flag.
module mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] lim,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] step_nxt;
  logic             step_boundary;
  logic [WIDTH-1:0] load_clamped;

  counter_next #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_next (
    .count    (count_q),
    .lim      (lim),
    .up       (up),
    .en       (en),
    .nxt      (step_nxt),
    .boundary (step_boundary)
  );

  assign load_clamped = (load_val > lim) ? lim : load_val;

  // Load suppresses any step, so it can never raise tc or set ovf.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q & ~clr_ovf;
    if (load) begin
      count_d = load_clamped;
    end else begin
      count_d = step_nxt;
      tc_d    = step_boundary;
      if (step_boundary) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule : mod_counter

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: a wrap-mode and a saturate-mode instance share
// stimulus, and every edge is checked against hand-computed expectations.
module tb_mod_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, en, up, load, clr_ovf;
  logic [W-1:0] load_val, lim;
  logic [W-1:0] count_w, count_s;
  logic         tc_w, tc_s, ovf_w, ovf_s;

  int n_pass  = 0;
  int n_total = 0;

  logic [W-1:0] exp_q[$];

  typedef struct packed {
    logic         rst;
    logic         load;
    logic [W-1:0] lv;
    logic         en;
    logic         up;
    logic [W-1:0] lim;
    logic         clr;
    logic [W-1:0] cw;
    logic         tw;
    logic         ow;
    logic [W-1:0] cs;
    logic         ts;
    logic         os;
  } vec_t;

  vec_t vecs[$];

  // clock / reset
  always #5 clk = ~clk;

  mod_counter #(.WIDTH(W), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .lim(lim), .clr_ovf(clr_ovf), .count(count_w), .tc(tc_w), .ovf(ovf_w)
  );

  mod_counter #(.WIDTH(W), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .lim(lim), .clr_ovf(clr_ovf), .count(count_s), .tc(tc_s), .ovf(ovf_s)
  );

  function automatic vec_t mk(input int r, input int ld, input int lv, input int e,
                              input int u, input int lm, input int c,
                              input int cw, input int tw, input int ow,
                              input int cs, input int ts, input int os);
    vec_t v;
    v.rst = r[0];   v.load = ld[0]; v.lv = lv[W-1:0]; v.en = e[0];
    v.up  = u[0];   v.lim = lm[W-1:0]; v.clr = c[0];
    v.cw  = cw[W-1:0]; v.tw = tw[0]; v.ow = ow[0];
    v.cs  = cs[W-1:0]; v.ts = ts[0]; v.os = os[0];
    return v;
  endfunction

  // driver tasks
  task automatic drive(input logic r, input logic ld, input logic [W-1:0] lv,
                       input logic e, input logic u, input logic [W-1:0] lm,
                       input logic c);
    rst = r; load = ld; load_val = lv; en = e; up = u; lim = lm; clr_ovf = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard
  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_both(input string tag, input logic tw, input logic ow,
                          input logic ts, input logic os);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    chk({tag, " count_wrap"}, int'(count_w), int'(e));
    e = exp_q.pop_front();
    chk({tag, " count_sat"}, int'(count_s), int'(e));
    chk({tag, " tc_wrap"}, int'(tc_w), int'(tw));
    chk({tag, " ovf_wrap"}, int'(ovf_w), int'(ow));
    chk({tag, " tc_sat"}, int'(tc_s), int'(ts));
    chk({tag, " ovf_sat"}, int'(ovf_s), int'(os));
  endtask

  initial begin
    drive(1'b1, 1'b1, 4'd7, 1'b1, 1'b1, 4'd9, 1'b0);
    step();
    step();
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd0);
    chk_both("reset", 1'b0, 1'b0, 1'b0, 1'b0);

    // wrap-up from reset: wrap instance rolls 9 -> 0, saturate instance pins at 9
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd9, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      exp_q.push_back(W'(i % 10));
      exp_q.push_back(W'((i <= 9) ? i : 9));
      step();
      chk_both($sformatf("wrapup%0d", i), (i == 10), (i >= 10), (i >= 10), (i >= 10));
    end

    //            rst ld lv en up lim clr  cw tw ow  cs ts os
    vecs.push_back(mk(1, 0, 0, 0, 0, 9, 0,   0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 1, 2, 1, 0, 9, 0,   2, 0, 0,  2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 9, 0,   1, 0, 0,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 9, 0,   0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 9, 0,   9, 1, 1,  0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 9, 0,   8, 0, 1,  0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 9, 1,   7, 0, 0,  0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 9, 1,   7, 0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 1, 12, 1, 1, 5, 0,  5, 0, 0,  5, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 5, 0,   0, 1, 1,  5, 1, 1));
    vecs.push_back(mk(0, 1, 9, 0, 0, 9, 1,   9, 0, 0,  9, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 3, 0,   8, 0, 0,  8, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 3, 0,   7, 0, 0,  7, 0, 0));
    vecs.push_back(mk(0, 1, 9, 0, 0, 9, 0,   9, 0, 0,  9, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 3, 0,   0, 1, 1,  3, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 9, 0,   1, 0, 1,  4, 0, 1));
    vecs.push_back(mk(1, 1, 5, 1, 1, 9, 0,   0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 9, 0,   0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 9, 0,   1, 0, 0,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0,   0, 1, 1,  0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0,   0, 1, 1,  0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0,   0, 1, 1,  0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,   0, 1, 1,  0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 9, 0,   0, 0, 1,  0, 0, 1));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].load, vecs[i].lv, vecs[i].en, vecs[i].up,
            vecs[i].lim, vecs[i].clr);
      exp_q.push_back(vecs[i].cw);
      exp_q.push_back(vecs[i].cs);
      step();
      chk_both($sformatf("row%0d", i), vecs[i].tw, vecs[i].ow, vecs[i].ts, vecs[i].os);
    end

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mod_counter

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: count width in bits, minimum 1.
REQ-002 SHALL have parameter SATURATE, default 0: 0 means the count wraps at a boundary; 1 means it holds at the boundary.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: step enable.
REQ-006 SHALL have port up, input, 1 bit: direction per cycle; 1 counts up, 0 counts down.
REQ-007 SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-008 SHALL have port load_val, input, WIDTH bits: value to load.
REQ-009 SHALL have port lim, input, WIDTH bits: runtime upper limit, giving a count range of 0..lim.
REQ-010 SHALL have port clr_ovf, input, 1 bit: clears the sticky overflow flag.
REQ-011 SHALL have port count, output, WIDTH bits: current count, registered.
REQ-012 SHALL have port tc, output, 1 bit: terminal-count pulse, registered, one cycle wide.
REQ-013 SHALL have port ovf, output, 1 bit: sticky boundary-event flag, registered.

Function
REQ-014 Update priority SHALL be: rst, then load, then en, then hold.
REQ-015 On load, count SHALL take min(load_val, lim) on the next edge, regardless of en and up; tc SHALL be 0 that cycle.
REQ-016 For en=1, up=1 and count < lim, count SHALL increment by 1.
REQ-017 For en=1, up=1 and count >= lim, the step is an up-boundary event: count SHALL go to 0 if SATURATE=0, or to lim if SATURATE=1.
REQ-018 For en=1, up=0 and count > 0, count SHALL decrement by 1; this includes count > lim after lim is lowered.
REQ-019 For en=1, up=0 and count == 0, the step is a down-boundary event: count SHALL go to lim if SATURATE=0, or stay 0 if SATURATE=1.
REQ-020 With en=0 and load=0, count SHALL hold; tc SHALL be 0.
REQ-021 tc SHALL be 1 in exactly the cycle after a boundary event and 0 otherwise; consecutive boundary events SHALL produce consecutive tc pulses.
REQ-022 ovf SHALL set on any boundary event and stay set until clr_ovf=1.
REQ-023 When a boundary event and clr_ovf occur in the same cycle, ovf SHALL end at 1 (set wins).
REQ-024 When lim=0, every enabled step SHALL be a boundary event: count stays 0 and tc pulses every enabled cycle, in both modes.
REQ-025 Arithmetic SHALL be WIDTH-bit unsigned; no intermediate result may escape the 0..max(lim, count) range except via REQ-018.
REQ-026 A change of lim SHALL take effect in the same cycle it is presented, with no pipelining of lim.
REQ-027 Latency: count, tc and ovf SHALL reflect inputs sampled at edge N at edge N (registered, one cycle), with no combinational input-to-output path.

Reset
REQ-028 On rst=1 at a rising edge, count SHALL become 0, tc 0 and ovf 0, overriding load, en and clr_ovf.
REQ-029 Reset asserted mid-count SHALL take effect at the next edge; no partial step and no tc SHALL follow the reset.
REQ-030 The first enabled step after reset release SHALL be evaluated from count=0.

Structure
REQ-031 A shared package, counter_pkg, SHALL hold the mode constants MODE_WRAP=0 and MODE_SAT=1 and the default WIDTH; SATURATE SHALL be compared against these constants.
REQ-032 Next-value computation SHALL live in one combinational sub-module, counter_next, with inputs count, lim, up, en and SATURATE and outputs nxt and boundary.
REQ-033 mod_counter SHALL hold all registers: count, tc and ovf.
REQ-034 No latches SHALL be inferred; all registers SHALL sit in a single clocked process.

Verification (WIDTH=4)
REQ-035 Wrap-up: SATURATE=0, lim=9, up=1, en=1 for 12 cycles from reset -> count 1..9, 0, 1, 2; tc high only the cycle count shows 0; ovf=1 afterwards.
REQ-036 Saturate-down: SATURATE=1, load 2, up=0, en=1 for 4 cycles -> count 1, 0, 0, 0; tc high on the 3rd and 4th results; ovf=1.
REQ-037 Load clamp and priority: lim=5, load=1, load_val=12, en=1, up=1 in the same cycle -> count=5, tc=0; the next enabled up step in wrap mode gives count=0, tc=1.
REQ-038 Lowered limit: count=9, then lim set to 3 with up=0 -> count 8, 7, ...; with up=1 instead -> wrap to 0 on the first step.
REQ-039 Flag race and reset: a boundary event with clr_ovf=1 -> ovf=1; then clr_ovf alone -> ovf=0; rst=1 during counting with load=1 -> count=0, tc=0, ovf=0 next cycle.
REQ-040 lim=0, en=1 for 3 cycles in either mode -> count stays 0 and tc=1 on each of the 3 cycles.
